memory_stage: RTL

MEMORY_STAGE -- requirements
Module: memory_stage

---
 rtl/riscv_pkg.sv | 50 +++++
 rtl/load_align.sv | 30 +++
 rtl/memory_stage.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared encodings and helpers for the load/store pipeline stage.
// Opcodes, funct3 sizes, exception bit positions and the MEM FSM state type.
package riscv_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  // Bit positions inside WB_EXC = {SAF, SAM, LAF, LAM}.
  localparam int EXC_LAM = 0;
  localparam int EXC_LAF = 1;
  localparam int EXC_SAM = 2;
  localparam int EXC_SAF = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

  function automatic logic [7:0] size_strobe(input logic [1:0] size);
    case (size)
      SZ_B:    return 8'h01;
      SZ_H:    return 8'h03;
      SZ_W:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] offset);
    case (size)
      SZ_H:    return offset[0];
      SZ_W:    return |offset[1:0];
      SZ_D:    return |offset;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Extracts the addressed bytes from a read doubleword and extends them to 64 bits.
module load_align
  import riscv_pkg::*;
(
  input  logic [63:0] rdata_i,
  input  logic [2:0]  offset_i,
  input  logic [2:0]  funct3_i,
  output logic [63:0] result_o
);

  logic [63:0] shifted;

  assign shifted = rdata_i >> {offset_i, 3'b000};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    result_o = '0;
    case (funct3_i)
      F3_LB:   result_o = {{56{shifted[7]}},  shifted[7:0]};
      F3_LH:   result_o = {{48{shifted[15]}}, shifted[15:0]};
      F3_LW:   result_o = {{32{shifted[31]}}, shifted[31:0]};
      F3_LD:   result_o = shifted;
      F3_LBU:  result_o = {56'd0, shifted[7:0]};
      F3_LHU:  result_o = {48'd0, shifted[15:0]};
      F3_LWU:  result_o = {32'd0, shifted[31:0]};
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// MEM pipeline stage: issues data-memory loads/stores, waits for the handshake,
// detects misalignment and access timeouts, and registers results into the WB latch.
module memory_stage
  import riscv_pkg::*;
#(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_v_i,
  input  logic [31:0] mem_ir_i,
  input  logic [18:0] mem_cst_i,
  input  logic [63:0] mem_alu_res_i,
  input  logic [63:0] mem_rs2_data_i,
  input  logic [63:0] mem_npc_i,
  input  logic [63:0] mem_target_address_i,
  input  logic [63:0] mem_csrfd_i,
  input  logic [63:0] mem_rfd_i,
  input  logic        mem_pc_mux_i,
  input  logic        flush_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [63:0] dmem_addr_o,
  output logic [63:0] dmem_wdata_o,
  output logic [7:0]  dmem_wstrb_o,
  input  logic        dmem_ack_i,
  input  logic [63:0] dmem_rdata_i,
  output logic        mem_stall_o,
  output logic        wb_v_o,
  output logic [31:0] wb_ir_o,
  output logic [18:0] wb_cst_o,
  output logic [63:0] wb_res_o,
  output logic        wb_pc_mux_o,
  output logic [63:0] wb_npc_o,
  output logic [63:0] wb_target_address_o,
  output logic [63:0] wb_csrfd_o,
  output logic [63:0] wb_rfd_o,
  output logic [3:0]  wb_exc_o
);

  localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        is_load, is_store, memop, illegal, misal, go;
  logic [63:0] live_addr, live_wdata;
  logic [7:0]  live_wstrb;

  mem_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        flush_q, flush_d;
  logic        capture;
  logic        req_c, stall_c, killed;

  logic [63:0] req_addr_q, req_wdata_q;
  logic [7:0]  req_wstrb_q;
  logic        req_we_q;
  logic [2:0]  req_f3_q, req_off_q;

  logic        in_wait;
  logic [63:0] cur_addr, cur_wdata, load_res;
  logic [7:0]  cur_wstrb;
  logic        cur_we;
  logic [2:0]  cur_f3, cur_off;

  logic        wb_v_d;
  logic [63:0] wb_res_d;
  logic [3:0]  wb_exc_d;

  logic        wb_v_q, wb_pc_mux_q;
  logic [31:0] wb_ir_q;
  logic [18:0] wb_cst_q;
  logic [63:0] wb_res_q, wb_npc_q, wb_target_address_q, wb_csrfd_q, wb_rfd_q;
  logic [3:0]  wb_exc_q;

  assign opcode   = mem_ir_i[6:0];
  assign funct3   = mem_ir_i[14:12];
  assign is_load  = (opcode == OPC_LOAD);
  assign is_store = (opcode == OPC_STORE);
  assign memop    = mem_v_i && (is_load || is_store) && !flush_i;
  assign illegal  = (is_load && funct3 == 3'b111) || (is_store && funct3[2]);
  assign misal    = misaligned(funct3[1:0], mem_alu_res_i[2:0]);
  assign go       = memop && !illegal && !misal;

  assign live_addr  = {mem_alu_res_i[63:3], 3'b000};
  assign live_wstrb = size_strobe(funct3[1:0]) << mem_alu_res_i[2:0];
  assign live_wdata = mem_rs2_data_i << {mem_alu_res_i[2:0], 3'b000};

  // While waiting, the bus is driven from the captured request so it cannot
  // drift if the MEM latch contents change underneath (e.g. after a flush).
  assign in_wait   = (state_q == ST_WAIT);
  assign cur_addr  = in_wait ? req_addr_q  : live_addr;
  assign cur_wdata = in_wait ? req_wdata_q : live_wdata;
  assign cur_wstrb = in_wait ? req_wstrb_q : live_wstrb;
  assign cur_we    = in_wait ? req_we_q    : is_store;
  assign cur_f3    = in_wait ? req_f3_q    : funct3;
  assign cur_off   = in_wait ? req_off_q   : mem_alu_res_i[2:0];

  load_align u_load_align (
    .rdata_i  (dmem_rdata_i),
    .offset_i (cur_off),
    .funct3_i (cur_f3),
    .result_o (load_res)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    flush_d  = flush_q;
    capture  = 1'b0;
    req_c    = 1'b0;
    stall_c  = 1'b0;
    killed   = 1'b0;
    wb_v_d   = 1'b0;
    wb_res_d = mem_alu_res_i;
    wb_exc_d = '0;
    case (state_q)
      ST_IDLE: begin
        flush_d = 1'b0;
        if (go) begin
          req_c = 1'b1;
          if (dmem_ack_i) begin
            wb_v_d   = 1'b1;
            wb_res_d = is_load ? load_res : mem_alu_res_i;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = '0;
            stall_c = 1'b1;
            capture = 1'b1;
          end
        end else begin
          wb_v_d = mem_v_i && !flush_i;
          if (memop && illegal) begin
            wb_res_d = '0;
          end else if (memop && misal) begin
            if (is_load) wb_exc_d[EXC_LAM] = 1'b1;
            else         wb_exc_d[EXC_SAM] = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        // A flush during the handshake only suppresses the writeback; the bus
        // transaction itself still completes so an accepted store is not torn.
        killed  = flush_q || flush_i;
        flush_d = killed;
        if (cnt_q == MAX_CNT) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          flush_d = 1'b0;
          wb_v_d  = !killed;
          if (!killed) begin
            if (req_we_q) wb_exc_d[EXC_SAF] = 1'b1;
            else          wb_exc_d[EXC_LAF] = 1'b1;
          end
        end else begin
          req_c = 1'b1;
          if (dmem_ack_i) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            flush_d  = 1'b0;
            wb_v_d   = !killed;
            wb_res_d = req_we_q ? mem_alu_res_i : load_res;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            stall_c = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
    end
  end

  // NOTE: the captured request is pure datapath, only read while in WAIT, so it
  // carries no reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      req_addr_q  <= live_addr;
      req_wdata_q <= live_wdata;
      req_wstrb_q <= live_wstrb;
      req_we_q    <= is_store;
      req_f3_q    <= funct3;
      req_off_q   <= mem_alu_res_i[2:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_v_q              <= 1'b0;
      wb_ir_q             <= '0;
      wb_cst_q            <= '0;
      wb_res_q            <= '0;
      wb_pc_mux_q         <= 1'b0;
      wb_npc_q            <= '0;
      wb_target_address_q <= '0;
      wb_csrfd_q          <= '0;
      wb_rfd_q            <= '0;
      wb_exc_q            <= '0;
    end else if (stall_c) begin
      wb_v_q <= 1'b0;
    end else begin
      wb_v_q              <= wb_v_d;
      wb_ir_q             <= mem_ir_i;
      wb_cst_q            <= mem_cst_i;
      wb_res_q            <= wb_res_d;
      wb_pc_mux_q         <= mem_pc_mux_i;
      wb_npc_q            <= mem_npc_i;
      wb_target_address_q <= mem_target_address_i;
      wb_csrfd_q          <= mem_csrfd_i;
      wb_rfd_q            <= mem_rfd_i;
      wb_exc_q            <= wb_exc_d;
    end
  end

  // Request and stall are forced low the moment reset asserts, even mid-handshake.
  assign dmem_req_o   = req_c && rst_n;
  assign mem_stall_o  = stall_c && rst_n;
  assign dmem_we_o    = dmem_req_o && cur_we;
  assign dmem_addr_o  = cur_addr;
  assign dmem_wdata_o = cur_wdata;
  assign dmem_wstrb_o = cur_wstrb;

  assign wb_v_o              = wb_v_q;
  assign wb_ir_o             = wb_ir_q;
  assign wb_cst_o            = wb_cst_q;
  assign wb_res_o            = wb_res_q;
  assign wb_pc_mux_o         = wb_pc_mux_q;
  assign wb_npc_o            = wb_npc_q;
  assign wb_target_address_o = wb_target_address_q;
  assign wb_csrfd_o          = wb_csrfd_q;
  assign wb_rfd_o            = wb_rfd_q;
  assign wb_exc_o            = wb_exc_q;

endmodule
